mem_port_arbiter: RTL and testbench

Shares one single-ported unified memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage, load/store). The block arbitrates requests, drives a req/ack memory handshake with variable latency, returns read data with a one-cycle valid pulse, and produces per-requester stall signals for the hazard logic. Data accesses have priority. A bounded-starvation counter guarantees forward progress for fetch.

---
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/mem_port_arbiter.sv | 90 +++++++++
 tb/tb_mem_port_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the shared memory port
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_kill;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_stall;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              d_stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  if_req, if_addr, if_kill, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, if_kill, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data, data first with bounded fetch starvation
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input logic            clk,
    input logic            rst_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, RESP} state_t;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    state_t     state;
    logic [3:0] streak;
    logic       kill;
    logic       fetch_first;

    // fetch wins when it is alone or has already waited out SMAX data grants
    assign fetch_first = bus.if_req && (!bus.d_req || streak == SMAX);

    // stalls hold each requester until its own valid pulse
    assign bus.if_stall = bus.if_req && !bus.if_valid;
    assign bus.d_stall  = bus.d_req && !bus.d_valid;

    // arbitration FSM with registered memory-side and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            streak        <= 4'd0;
            kill          <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_rdata  <= '0;
            bus.if_valid  <= 1'b0;
            bus.d_rdata   <= '0;
            bus.d_valid   <= 1'b0;
        end else begin
            bus.if_valid <= 1'b0;
            bus.d_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (fetch_first) begin
                        state         <= IBUSY;
                        streak        <= 4'd0;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= ADDR_W'(bus.if_addr);
                        bus.mem_wdata <= DATA_W'(0);
                    end else if (bus.d_req) begin
                        state         <= DBUSY;
                        streak        <= bus.if_req ? ((streak == SMAX) ? streak : streak + 4'd1) : 4'd0;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= bus.d_we;
                        bus.mem_addr  <= bus.d_addr;
                        bus.mem_wdata <= bus.d_wdata;
                    end else begin
                        streak <= 4'd0;
                    end
                end
                IBUSY: begin
                    if (bus.if_kill) kill <= 1'b1;
                    if (bus.mem_ack) begin
                        state       <= RESP;
                        bus.mem_req <= 1'b0;
                        if (!(kill || bus.if_kill)) begin
                            bus.if_rdata <= bus.mem_rdata;
                            bus.if_valid <= 1'b1;
                        end
                    end
                end
                DBUSY: begin
                    if (bus.mem_ack) begin
                        state       <= RESP;
                        bus.mem_req <= 1'b0;
                        bus.d_valid <= 1'b1;
                        if (!bus.mem_we) bus.d_rdata <= bus.mem_rdata;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    kill  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random requesters and memory against a transaction-level reference model
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SM = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference model: who owns the port, whether we are in the response beat,
    // and what the memory and response sides must show
    int          owner;
    bit          in_resp;
    int          resp_owner;
    bit          killed;
    int          waited;
    bit          e_req, e_we;
    logic [31:0] e_addr, e_wdata, e_if_rdata, e_d_rdata;
    bit          e_if_valid, e_d_valid;
    bit          i_done, d_done;
    int          lat, lat_cnt, lat_max;
    int          p_if, p_d, p_kill;
    int          grants_if, grants_d;

    task automatic model_reset();
        owner = 0; in_resp = 0; resp_owner = 0; killed = 0; waited = 0;
        e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0;
        e_if_rdata = 0; e_d_rdata = 0; e_if_valid = 0; e_d_valid = 0;
        lat = -1; lat_cnt = 0;
    endtask

    task automatic drive();
        if (!bus.if_req || i_done) begin
            bus.if_req  = ($urandom_range(99) < p_if);
            bus.if_addr = $urandom & ~32'h3;
            i_done = 0;
        end
        if (!bus.d_req || d_done) begin
            bus.d_req   = ($urandom_range(99) < p_d);
            bus.d_we    = $urandom_range(1);
            bus.d_addr  = $urandom & ~32'h3;
            bus.d_wdata = $urandom;
            d_done = 0;
        end
        bus.if_kill = in_resp ? 1'b0 : (owner == 1) ? ($urandom_range(99) < p_kill) : ($urandom_range(99) < 5);
        if (owner != 0 && !in_resp) begin
            if (lat < 0) begin
                lat = $urandom_range(lat_max);
                lat_cnt = 0;
            end
            bus.mem_ack = (lat_cnt == lat);
            lat_cnt++;
        end else begin
            bus.mem_ack = ($urandom_range(99) < 10);
        end
        bus.mem_rdata = $urandom;
    endtask

    task automatic check_all();
        check("mem_req", bus.mem_req, e_req);
        if (e_req) begin
            check("mem_we", bus.mem_we, e_we);
            check("mem_addr", bus.mem_addr, e_addr);
            if (e_we) check("mem_wdata", bus.mem_wdata, e_wdata);
        end
        check("if_valid", bus.if_valid, e_if_valid);
        check("d_valid", bus.d_valid, e_d_valid);
        check("if_rdata", bus.if_rdata, e_if_rdata);
        check("d_rdata", bus.d_rdata, e_d_rdata);
        check("if_stall", bus.if_stall, bus.if_req & ~e_if_valid);
        check("d_stall", bus.d_stall, bus.d_req & ~e_d_valid);
    endtask

    // advance the model by one clock using the inputs currently applied
    task automatic step();
        bit nv_i, nv_d;
        nv_i = 0;
        nv_d = 0;
        if (in_resp) begin
            in_resp = 0;
            killed = 0;
            if (resp_owner == 1) i_done = 1; else d_done = 1;
        end else if (owner != 0) begin
            if (owner == 1 && bus.if_kill) killed = 1;
            if (bus.mem_ack) begin
                e_req = 0;
                in_resp = 1;
                resp_owner = owner;
                lat = -1;
                if (owner == 1 && !killed) begin
                    e_if_rdata = bus.mem_rdata;
                    nv_i = 1;
                end
                if (owner == 2) begin
                    nv_d = 1;
                    if (!e_we) e_d_rdata = bus.mem_rdata;
                end
                owner = 0;
            end
        end else if (bus.if_req && (!bus.d_req || waited >= SM)) begin
            owner = 1; e_req = 1; e_we = 0; e_addr = bus.if_addr; e_wdata = 0;
            waited = 0;
            grants_if++;
        end else if (bus.d_req) begin
            owner = 2; e_req = 1; e_we = bus.d_we; e_addr = bus.d_addr; e_wdata = bus.d_wdata;
            waited = bus.if_req ? waited + 1 : 0;
            grants_d++;
        end else begin
            waited = 0;
        end
        e_if_valid = nv_i;
        e_d_valid = nv_d;
    endtask

    initial begin
        bit rst_pend;
        bus.if_req = 0; bus.if_addr = 0; bus.if_kill = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        bus.mem_ack = 0; bus.mem_rdata = 0;
        i_done = 0; d_done = 0; grants_if = 0; grants_d = 0;
        model_reset();
        p_if = 0; p_d = 0; p_kill = 0; lat_max = 0;
        @(negedge clk);
        bus.if_req = 1;
        bus.if_addr = 32'h10;
        @(negedge clk);
        drive();
        #1;
        check_all();
        #1 rst_n = 1'b1;
        step();
        for (int ph = 0; ph < 4; ph++) begin
            p_if    = (ph == 0) ? 30 : (ph == 2) ? 100 : 60;
            p_d     = (ph == 0) ? 0 : (ph == 2) ? 100 : 50;
            p_kill  = (ph == 3) ? 30 : 10;
            lat_max = (ph == 0) ? 1 : 5;
            rst_pend = (ph != 0);
            for (int c = 0; c < 1500; c++) begin
                @(negedge clk);
                drive();
                #1;
                check_all();
                if (rst_pend && c > 700 && owner == 2 && !in_resp) begin
                    rst_pend = 0;
                    rst_n = 1'b0;
                    #1;
                    check("rst_mem_req", bus.mem_req, 1'b0);
                    check("rst_d_valid", bus.d_valid, 1'b0);
                    model_reset();
                    #1 rst_n = 1'b1;
                end
                step();
            end
        end
        check("fetch_progress", (grants_if > 0 && grants_d > 0), 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
